// File: rtl/core_scheduler.sv
// rtl/core_scheduler.sv - per-core SIMT instruction scheduler FSM
// Steps a block through fetch/decode/request/wait/execute/update, tracking PC, divergence and retirement.
module core_scheduler #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [THREADS-1:0]         thread_mask,
  input  logic [2:0]                 fetcher_state,
  input  logic [2*THREADS-1:0]       lsu_state,
  input  logic                       decoded_ret,
  input  logic [THREADS*PC_BITS-1:0] next_pc,
  output logic [2:0]                 core_state,
  output logic [PC_BITS-1:0]         current_pc,
  output logic [THREADS-1:0]         active_mask,
  output logic                       done,
  output logic                       diverged,
  output logic [15:0]                retired_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_t;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  state_t             state;
  logic               lsu_busy;
  logic               sel_found;
  logic               pc_mismatch;
  logic [PC_BITS-1:0] sel_pc;

  assign core_state = state;

  // Only enabled threads can stall WAIT or vote on the next PC.
  always_comb begin
    lsu_busy    = 1'b0;
    sel_found   = 1'b0;
    pc_mismatch = 1'b0;
    sel_pc      = current_pc + {{(PC_BITS-1){1'b0}}, 1'b1};
    for (int i = 0; i < THREADS; i++) begin
      if (active_mask[i] && (lsu_state[2*i +: 2] == 2'b01 || lsu_state[2*i +: 2] == 2'b10))
        lsu_busy = 1'b1;
      if (active_mask[i] && !sel_found) begin
        sel_pc    = next_pc[i*PC_BITS +: PC_BITS];
        sel_found = 1'b1;
      end
    end
    for (int i = 0; i < THREADS; i++) begin
      if (active_mask[i] && next_pc[i*PC_BITS +: PC_BITS] != sel_pc)
        pc_mismatch = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      current_pc    <= '0;
      active_mask   <= '0;
      done          <= 1'b0;
      diverged      <= 1'b0;
      retired_count <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_FETCH;
            active_mask   <= thread_mask;
            current_pc    <= '0;
            done          <= 1'b0;
            diverged      <= 1'b0;
            retired_count <= 16'd0;
          end
        end
        S_FETCH: begin
          if (fetcher_state == FETCHER_FETCHED)
            state <= S_DECODE;
        end
        S_DECODE:  state <= S_REQUEST;
        S_REQUEST: state <= S_WAIT;
        S_WAIT: begin
          if (!lsu_busy)
            state <= S_EXECUTE;
        end
        S_EXECUTE: state <= S_UPDATE;
        S_UPDATE: begin
          if (pc_mismatch)
            diverged <= 1'b1;
          if (retired_count != 16'hFFFF)
            retired_count <= retired_count + 16'd1;
          if (decoded_ret) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            current_pc <= sel_pc;
            state      <= S_FETCH;
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_scheduler.sv
// tb/tb_core_scheduler.sv - self-checking bench for core_scheduler
// Directed vector table, hand-written corner sequences, and randomized runs against an instruction-level model.
module tb_core_scheduler;

  localparam int T  = 4;
  localparam int PB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [T-1:0]  thread_mask;
  logic [2:0]    fetcher_state;
  logic [2*T-1:0] lsu_state;
  logic          decoded_ret;
  logic [T*PB-1:0] next_pc;
  logic [2:0]    core_state;
  logic [PB-1:0] current_pc;
  logic [T-1:0]  active_mask;
  logic          done;
  logic          diverged;
  logic [15:0]   retired_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  core_scheduler #(.THREADS(T), .PC_BITS(PB)) dut (
    .clk(clk), .reset(reset), .start(start), .thread_mask(thread_mask),
    .fetcher_state(fetcher_state), .lsu_state(lsu_state), .decoded_ret(decoded_ret),
    .next_pc(next_pc), .core_state(core_state), .current_pc(current_pc),
    .active_mask(active_mask), .done(done), .diverged(diverged), .retired_count(retired_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] fetch_noise();
    logic [2:0] n;
    n = 3'($urandom_range(0, 7));
    if (n == 3'b010) n = 3'b011;
    return n;
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; fetcher_state = 3'b000; lsu_state = '0; decoded_ret = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic launch(input logic [T-1:0] mask);
    thread_mask = mask;
    start = 1'b1;
    tick();
    start = 1'b0;
    thread_mask = T'($urandom);
    chk("launch_mask", 32'(active_mask), 32'(mask));
  endtask

  // Drives one instruction from FETCH through UPDATE, checking the state every cycle.
  task automatic run_instr(input int fdly, input int st, input int sn, input logic [1:0] code,
                           input logic [31:0] npc, input bit ret, input int exp_wait,
                           input logic [7:0] junk);
    logic [7:0] lw;
    decoded_ret = 1'b0;
    lsu_state   = junk;
    for (int c = 0; c <= fdly; c++) begin
      chk("st_fetch", 32'(core_state), 32'h1);
      fetcher_state = (c == fdly) ? 3'b010 : fetch_noise();
      start = 1'($urandom_range(0, 1));
      tick();
    end
    fetcher_state = 3'b000;
    chk("st_decode", 32'(core_state), 32'h2);
    tick();
    chk("st_request", 32'(core_state), 32'h3);
    tick();
    for (int w = 0; w <= exp_wait; w++) begin
      chk("st_wait", 32'(core_state), 32'h4);
      lw = junk;
      if (w < sn) lw[2*st +: 2] = code;
      lsu_state = lw;
      tick();
    end
    lsu_state = junk;
    chk("st_execute", 32'(core_state), 32'h5);
    next_pc = npc;
    decoded_ret = ret;
    tick();
    chk("st_update", 32'(core_state), 32'h6);
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    bit          launch;
    logic [3:0]  mask;
    int          fdly;
    int          st;
    int          sn;
    logic [31:0] npc;
    bit          ret;
    int          exp_wait;
    logic [7:0]  exp_pc;
    bit          exp_div;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [T-1:0] mask;
    logic [7:0]   m_pc, sel, base;
    logic         m_div;
    logic [15:0]  m_cnt;
    logic [31:0]  npc;
    logic [7:0]   junk;
    logic [7:0]   q[$];
    int           n_ins, fdly, st, sn, ew;
    bit           ret;
    logic [1:0]   code;

    tbl[0] = '{1, 4'b1111, 0, 0, 0, 32'h01010101, 0, 0, 8'h01, 0, 16'd1};
    tbl[1] = '{0, 4'b1111, 0, 2, 5, 32'h05050905, 0, 5, 8'h05, 1, 16'd2};
    tbl[2] = '{0, 4'b1111, 0, 0, 0, 32'h0A0A0A0A, 0, 0, 8'h0A, 1, 16'd3};
    tbl[3] = '{0, 4'b1111, 2, 0, 0, 32'h07070707, 1, 0, 8'h0A, 1, 16'd4};
    tbl[4] = '{1, 4'b1011, 0, 2, 5, 32'h20772020, 0, 0, 8'h20, 0, 16'd1};
    tbl[5] = '{0, 4'b1011, 1, 3, 2, 32'hFF00FFFF, 0, 2, 8'hFF, 0, 16'd2};
    tbl[6] = '{0, 4'b1011, 0, 0, 1, 32'h10101011, 0, 1, 8'h11, 1, 16'd3};

    thread_mask = '0; next_pc = '0;
    do_reset();
    chk("rst_state", 32'(core_state), 32'h0);
    chk("rst_pc", 32'(current_pc), 32'h0);
    chk("rst_mask", 32'(active_mask), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_div", 32'(diverged), 32'h0);
    chk("rst_cnt", 32'(retired_count), 32'h0);

    // Idle without start stays idle.
    tick(); tick();
    chk("idle_hold", 32'(core_state), 32'h0);

    foreach (tbl[k]) begin
      if (tbl[k].launch) begin
        do_reset();
        launch(tbl[k].mask);
      end
      run_instr(tbl[k].fdly, tbl[k].st, tbl[k].sn, 2'b10, tbl[k].npc, tbl[k].ret, tbl[k].exp_wait, 8'h00);
      chk("vec_pc", 32'(current_pc), 32'(tbl[k].exp_pc));
      chk("vec_div", 32'(diverged), 32'(tbl[k].exp_div));
      chk("vec_cnt", 32'(retired_count), 32'(tbl[k].exp_cnt));
      chk("vec_done", 32'(done), 32'(tbl[k].ret));
      chk("vec_next", 32'(core_state), tbl[k].ret ? 32'h7 : 32'h1);
      if (tbl[k].ret) begin
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
          tick();
          chk("done_state", 32'(core_state), 32'h7);
          chk("done_flag", 32'(done), 32'h1);
          chk("done_cnt", 32'(retired_count), 32'(tbl[k].exp_cnt));
          chk("done_pc", 32'(current_pc), 32'(tbl[k].exp_pc));
        end
        start = 1'b0;
      end
    end

    // Empty mask: PC advances by one and wraps after 0xFF.
    do_reset();
    launch(4'b0000);
    for (int k = 0; k < 256; k++) begin
      run_instr(0, 0, 2, 2'b01, 32'hDEADBEEF, 0, 0, 8'h00);
      if (k == 254) chk("wrap_ff", 32'(current_pc), 32'hFF);
      if (k == 255) chk("wrap_00", 32'(current_pc), 32'h00);
    end
    chk("wrap_cnt", 32'(retired_count), 32'd256);
    chk("wrap_div", 32'(diverged), 32'h0);

    // Reset while stalled in WAIT, with start also asserted.
    do_reset();
    launch(4'b1111);
    run_instr(0, 0, 0, 2'b10, 32'h03030304, 0, 0, 8'h00);
    fetcher_state = 3'b010; tick();
    fetcher_state = 3'b000; lsu_state = 8'b00100000; tick();
    tick();
    chk("mid_wait", 32'(core_state), 32'h4);
    tick();
    chk("mid_wait2", 32'(core_state), 32'h4);
    reset = 1'b1; start = 1'b1; thread_mask = 4'b1111;
    tick();
    reset = 1'b0; start = 1'b0; lsu_state = '0;
    chk("rw_state", 32'(core_state), 32'h0);
    chk("rw_pc", 32'(current_pc), 32'h0);
    chk("rw_mask", 32'(active_mask), 32'h0);
    chk("rw_done", 32'(done), 32'h0);
    chk("rw_div", 32'(diverged), 32'h0);
    chk("rw_cnt", 32'(retired_count), 32'h0);

    // Randomized launches against the instruction-level model.
    for (int r = 0; r < 40; r++) begin
      do_reset();
      mask = ($urandom_range(0, 4) == 0) ? 4'b0000 : T'($urandom);
      launch(mask);
      m_pc = 8'h00; m_div = 1'b0; m_cnt = 16'd0;
      n_ins = $urandom_range(1, 6);
      for (int k = 0; k < n_ins; k++) begin
        fdly = $urandom_range(0, 3);
        st   = $urandom_range(0, 3);
        sn   = $urandom_range(0, 3);
        code = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        for (int i = 0; i < T; i++) begin
          if (mask[i]) junk[2*i +: 2] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
          else         junk[2*i +: 2] = 2'($urandom);
        end
        base = 8'($urandom);
        for (int i = 0; i < T; i++)
          npc[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : base;
        ret = (k == n_ins - 1) && ($urandom_range(0, 1) == 1);
        ew  = mask[st] ? sn : 0;
        run_instr(fdly, st, sn, code, npc, ret, ew, junk);

        q.delete();
        for (int i = 0; i < T; i++)
          if (mask[i]) q.push_back(npc[i*8 +: 8]);
        sel = (q.size() > 0) ? q[0] : m_pc + 8'd1;
        foreach (q[j]) if (q[j] != sel) m_div = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (!ret) m_pc = sel;

        chk("rnd_pc", 32'(current_pc), 32'(m_pc));
        chk("rnd_div", 32'(diverged), 32'(m_div));
        chk("rnd_cnt", 32'(retired_count), 32'(m_cnt));
        chk("rnd_done", 32'(done), 32'(ret));
        chk("rnd_mask", 32'(active_mask), 32'(mask));
        chk("rnd_next", 32'(core_state), ret ? 32'h7 : 32'h1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
